fwd_hazard_unit: RTL

Parametrised operand-forwarding and load-use hazard unit for the RISC-V core pipeline. It tracks every in-flight register write in a DEPTH-entry shift scoreboard behind the issue stage. For each source operand it reports which pipeline stage supplies the youngest value and what kind of result bus that stage drives. It raises a stall when a load result is not yet forwardable, and keeps a saturating stall-cycle performance counter.

---
 rtl/fwd_hazard_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module  : fwd_hazard_unit
// Brief   : Operand-forwarding select and load-use stall generation for the
//           RISC-V pipeline. A DEPTH-entry shift scoreboard records every
//           in-flight register write behind issue; each source operand is
//           matched against it (youngest wins) and a stall is raised while a
//           matching load result is not yet forwardable. A saturating counter
//           accumulates stall cycles.
// Revision: 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
  parameter int DEPTH            = 2,
  parameter int REG_AW           = 5,
  parameter int LOAD_READY_STAGE = 1,
  parameter int SEL_W            = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_valid,
  input  logic [REG_AW-1:0]       issue_rs1,
  input  logic [REG_AW-1:0]       issue_rs2,
  input  logic                    issue_use_rs1,
  input  logic                    issue_use_rs2,
  input  logic [REG_AW-1:0]       issue_rd,
  input  logic                    issue_wen,
  input  logic [1:0]              issue_kind,
  input  logic                    flush,
  input  logic                    perf_clr,
  output logic                    stall,
  output logic [SEL_W-1:0]        fwd_sel_1,
  output logic [SEL_W-1:0]        fwd_sel_2,
  output logic [1:0]              fwd_kind_1,
  output logic [1:0]              fwd_kind_2,
  output logic [DEPTH-1:0]        stage_valid,
  output logic [DEPTH*REG_AW-1:0] stage_rd,
  output logic [31:0]             stall_count
);

  localparam logic [1:0] c_KIND_ALU  = 2'd0;
  localparam logic [1:0] c_KIND_LOAD = 2'd1;
  localparam logic [1:0] c_KIND_RSVD = 2'd3;

  // Scoreboard entries: index 0 is the youngest, DEPTH-1 the writeback stage.
  logic [DEPTH-1:0]  r_valid;
  logic [REG_AW-1:0] r_rd   [DEPTH];
  logic [1:0]        r_kind [DEPTH];
  logic [31:0]       r_stall_count;

  logic       w_capture;
  logic [1:0] w_kind_in;
  logic       w_hazard_1;
  logic       w_hazard_2;

  // An issuing write is tracked only if it really leaves issue this cycle
  // and targets a real register; kind 3 is folded onto the ALU kind.
  assign w_capture = issue_valid & issue_wen & (issue_rd != '0) & ~stall & ~flush;
  assign w_kind_in = (issue_kind == c_KIND_RSVD) ? c_KIND_ALU : issue_kind;

  // Shift the scoreboard every cycle; a bubble enters when nothing is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_kind[i] <= c_KIND_ALU;
      end
    end else begin
      r_valid[0] <= w_capture;
      r_rd[0]    <= w_capture ? issue_rd : '0;
      r_kind[0]  <= w_capture ? w_kind_in : c_KIND_ALU;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_rd[i]    <= r_rd[i-1];
        r_kind[i]  <= r_kind[i-1];
      end
    end
  end

  // One identical matcher per source operand.
  genvar n;
  generate
    for (n = 0; n < 2; n++) begin : g_opnd
      logic [REG_AW-1:0] w_rs;
      logic              w_use;
      logic [SEL_W-1:0]  w_sel;
      logic [1:0]        w_kind;
      logic              w_hazard;

      assign w_rs  = (n == 0) ? issue_rs1 : issue_rs2;
      assign w_use = (n == 0) ? issue_use_rs1 : issue_use_rs2;

      // Scan oldest to youngest so the youngest matching entry has the last word.
      always_comb begin
        w_sel    = '0;
        w_kind   = c_KIND_ALU;
        w_hazard = 1'b0;
        if (w_use && (w_rs != '0)) begin
          for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_rd[i] == w_rs)) begin
              w_sel    = SEL_W'(i + 1);
              w_kind   = r_kind[i];
              w_hazard = (r_kind[i] == c_KIND_LOAD) && (i < LOAD_READY_STAGE);
            end
          end
        end
      end
    end
  endgenerate

  assign fwd_sel_1  = g_opnd[0].w_sel;
  assign fwd_kind_1 = g_opnd[0].w_kind;
  assign w_hazard_1 = g_opnd[0].w_hazard;
  assign fwd_sel_2  = g_opnd[1].w_sel;
  assign fwd_kind_2 = g_opnd[1].w_kind;
  assign w_hazard_2 = g_opnd[1].w_hazard;

  // A redirect kills the issuing instruction, so it can never be held.
  assign stall = issue_valid & ~flush & (w_hazard_1 | w_hazard_2);

  // Stall-cycle counter: clear wins, otherwise count up and stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (perf_clr) begin
      r_stall_count <= '0;
    end else if (stall && (r_stall_count != 32'hFFFF_FFFF)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
  assign stage_valid = r_valid;

  genvar p;
  generate
    for (p = 0; p < DEPTH; p++) begin : g_pack
      assign stage_rd[p*REG_AW +: REG_AW] = r_rd[p];
    end
  endgenerate

endmodule
`default_nettype wire
